// File: rtl/servo_pkg.sv
// Shared types and defaults for the servo command and PWM blocks.
// Both servo_cmd_slew and servo import this package.
package servo_pkg;

    typedef logic [15:0] pulse_us_t;

    localparam int unsigned SERVO_CLK_HZ   = 100_000_000;
    localparam int unsigned SERVO_FRAME_US = 20_000;

    localparam pulse_us_t SERVO_MIN_US    = 16'd1000;
    localparam pulse_us_t SERVO_MAX_US    = 16'd2000;
    localparam pulse_us_t SERVO_CENTER_US = 16'd1500;
    localparam pulse_us_t SERVO_STEP_US   = 16'd10;

    typedef enum logic {
        SETTLED = 1'b0,
        SLEWING = 1'b1
    } slew_state_t;

    function automatic pulse_us_t clamp_us(
        input pulse_us_t v,
        input pulse_us_t lo,
        input pulse_us_t hi
    );
        pulse_us_t r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Microsecond prescaler plus frame counter.
// frame_tick is high on the last clock of each PWM frame.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ   = SERVO_CLK_HZ,
    parameter int unsigned FRAME_US = SERVO_FRAME_US
) (
    input  logic clk_in,
    input  logic rst_n_in,
    output logic frame_tick
);

    localparam int unsigned PRE_N = CLK_HZ / 1_000_000;
    localparam int PRE_W = ($clog2(PRE_N) > 0) ? $clog2(PRE_N) : 1;
    localparam int FRM_W = ($clog2(FRAME_US) > 0) ? $clog2(FRAME_US) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_N - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_US - 1);

    logic [PRE_W-1:0] pre_q;
    logic [FRM_W-1:0] frm_q;
    logic             pre_last;
    logic             frm_last;

    assign pre_last   = (pre_q == PRE_LAST);
    assign frm_last   = (frm_q == FRM_LAST);
    assign frame_tick = pre_last && frm_last;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pre_q <= '0;
            frm_q <= '0;
        end else begin
            if (pre_last) begin
                pre_q <= '0;
                frm_q <= frm_last ? '0 : frm_q + 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/servo_cmd_slew.sv
// Target pulse-width intake with clamp and per-frame slew limiting.
// Outputs feed the servo PWM generator directly.
module servo_cmd_slew
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = SERVO_CLK_HZ,
    parameter int unsigned FRAME_US  = SERVO_FRAME_US,
    parameter pulse_us_t   MIN_US    = SERVO_MIN_US,
    parameter pulse_us_t   MAX_US    = SERVO_MAX_US,
    parameter pulse_us_t   CENTER_US = SERVO_CENTER_US,
    parameter pulse_us_t   STEP_US   = SERVO_STEP_US
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] target_in,
    input  logic        target_valid_in,
    output logic        target_ready_out,
    output logic [15:0] width_out,
    output logic        frame_out,
    output logic        settled_out
);

    localparam logic signed [16:0] STEP_S = $signed({1'b0, STEP_US});

    logic        frame_tick;
    logic        accept;
    pulse_us_t   slot_q;
    logic        slot_full_q;
    pulse_us_t   active_q;
    pulse_us_t   width_q;
    logic        frame_q;
    slew_state_t state_q;

    pulse_us_t          active_nxt;
    pulse_us_t          width_nxt;
    logic               slot_full_nxt;
    logic signed [16:0] diff;

    servo_frame_timer #(
        .CLK_HZ   (CLK_HZ),
        .FRAME_US (FRAME_US)
    ) u_timer (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .frame_tick (frame_tick)
    );

    assign accept = target_valid_in && !slot_full_q;

    // A target accepted on the frame edge lands in the slot, not in active.
    always_comb begin
        active_nxt    = active_q;
        slot_full_nxt = slot_full_q;
        width_nxt     = width_q;
        if (frame_tick && slot_full_q) begin
            active_nxt    = slot_q;
            slot_full_nxt = 1'b0;
        end
        if (accept) begin
            slot_full_nxt = 1'b1;
        end
        diff = $signed({1'b0, active_nxt}) - $signed({1'b0, width_q});
        if (frame_tick) begin
            if (diff > STEP_S) begin
                width_nxt = width_q + STEP_US;
            end else if (diff < -STEP_S) begin
                width_nxt = width_q - STEP_US;
            end else begin
                width_nxt = active_nxt;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            slot_q      <= CENTER_US;
            slot_full_q <= 1'b0;
            active_q    <= CENTER_US;
            width_q     <= CENTER_US;
            frame_q     <= 1'b0;
            state_q     <= SETTLED;
        end else begin
            if (accept) begin
                slot_q <= clamp_us(target_in, MIN_US, MAX_US);
            end
            slot_full_q <= slot_full_nxt;
            active_q    <= active_nxt;
            width_q     <= width_nxt;
            frame_q     <= frame_tick;
            unique case (state_q)
                SETTLED: begin
                    if (slot_full_nxt || (active_nxt != width_nxt)) begin
                        state_q <= SLEWING;
                    end
                end
                SLEWING: begin
                    if (!slot_full_nxt && (active_nxt == width_nxt)) begin
                        state_q <= SETTLED;
                    end
                end
                default: state_q <= SETTLED;
            endcase
        end
    end

    assign target_ready_out = !slot_full_q;
    assign width_out        = width_q;
    assign frame_out        = frame_q;
    assign settled_out      = (state_q == SETTLED);

endmodule

// File: tb/tb_servo_cmd_slew.sv
// Directed bench for servo_cmd_slew with hand-computed expectations.
// Clock is scaled to 10 MHz so a 20 us frame is 200 cycles.
module tb_servo_cmd_slew;

    localparam int unsigned CLK_HZ    = 10_000_000;
    localparam int unsigned FRAME_US  = 20;
    localparam int          FRAME_CYC = (CLK_HZ / 1_000_000) * FRAME_US;

    logic        clk;
    logic        rst_n;
    logic [15:0] target;
    logic        target_valid;
    logic        target_ready;
    logic [15:0] width;
    logic        frame;
    logic        settled;

    int n_vec = 0;
    int n_err = 0;

    servo_cmd_slew #(
        .CLK_HZ    (CLK_HZ),
        .FRAME_US  (FRAME_US),
        .MIN_US    (16'd1000),
        .MAX_US    (16'd2000),
        .CENTER_US (16'd1500),
        .STEP_US   (16'd10)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .target_in        (target),
        .target_valid_in  (target_valid),
        .target_ready_out (target_ready),
        .width_out        (width),
        .frame_out        (frame),
        .settled_out      (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns cycles until the next frame strobe; a timeout is a failure.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame && n < FRAME_CYC + 50);
        chk("frame_seen", {31'd0, frame}, 32'd1);
    endtask

    initial begin
        int n;
        int cnt;
        int hi;
        int lo;
        int held;

        rst_n        = 1'b0;
        target       = 16'd0;
        target_valid = 1'b0;

        // reset and timebase
        step(2);
        chk("rst_width", {16'd0, width}, 32'd1500);
        chk("rst_ready", {31'd0, target_ready}, 32'd1);
        chk("rst_settled", {31'd0, settled}, 32'd1);
        chk("rst_frame", {31'd0, frame}, 32'd0);
        rst_n = 1'b1;
        wait_frame(n);
        chk("first_frame", n, FRAME_CYC);
        chk("first_width", {16'd0, width}, 32'd1500);
        wait_frame(n);
        chk("frame_period", n, FRAME_CYC);

        // ramp up to 1600
        target_valid = 1'b1;
        target       = 16'd1600;
        step(1);
        target_valid = 1'b0;
        chk("ramp_ready_low", {31'd0, target_ready}, 32'd0);
        chk("ramp_busy", {31'd0, settled}, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            wait_frame(n);
            chk("ramp_period", n, (k == 1) ? FRAME_CYC - 1 : FRAME_CYC);
            chk("ramp_width", {16'd0, width}, 1500 + 10 * k);
            chk("ramp_settled", {31'd0, settled}, (k == 10) ? 1 : 0);
            if (k == 1) chk("ramp_ready_back", {31'd0, target_ready}, 32'd1);
        end
        step(1);
        chk("strobe_one_cycle", {31'd0, frame}, 32'd0);
        wait_frame(n);
        chk("ramp_hold", {16'd0, width}, 32'd1600);

        // clamp high
        target_valid = 1'b1;
        target       = 16'd2500;
        step(1);
        target_valid = 1'b0;
        cnt = 0;
        hi  = 0;
        do begin
            wait_frame(n);
            cnt++;
            if (int'(width) > hi) hi = int'(width);
        end while (!settled && cnt < 60);
        chk("clamp_hi_frames", cnt, 40);
        chk("clamp_hi_width", {16'd0, width}, 32'd2000);
        chk("clamp_hi_max", hi, 2000);

        // clamp low
        target_valid = 1'b1;
        target       = 16'd300;
        step(1);
        target_valid = 1'b0;
        cnt = 0;
        lo  = 65535;
        do begin
            wait_frame(n);
            cnt++;
            if (int'(width) < lo) lo = int'(width);
        end while (!settled && cnt < 120);
        chk("clamp_lo_frames", cnt, 100);
        chk("clamp_lo_width", {16'd0, width}, 32'd1000);
        chk("clamp_lo_min", lo, 1000);

        // backpressure: 1600 then 1400 back to back
        target_valid = 1'b1;
        target       = 16'd1600;
        step(1);
        chk("bp_first_taken", {31'd0, target_ready}, 32'd0);
        target = 16'd1400;
        held   = 0;
        cnt    = 0;
        do begin
            step(1);
            cnt++;
            if (!frame && target_ready) held++;
        end while (!frame && cnt < FRAME_CYC + 50);
        chk("bp_frame_seen", {31'd0, frame}, 32'd1);
        chk("bp_ready_held_low", held, 0);
        chk("bp_ready_at_frame", {31'd0, target_ready}, 32'd1);
        chk("bp_width", {16'd0, width}, 32'd1010);
        step(1);
        target_valid = 1'b0;
        chk("bp_second_taken", {31'd0, target_ready}, 32'd0);
        wait_frame(n);
        chk("bp_width2", {16'd0, width}, 32'd1020);
        chk("bp_ready2", {31'd0, target_ready}, 32'd1);

        // reposition to centre via reset
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        chk("rst2_width", {16'd0, width}, 32'd1500);
        wait_frame(n);
        chk("rst2_period", n, FRAME_CYC);

        // reversal mid-slew
        target_valid = 1'b1;
        target       = 16'd1600;
        step(1);
        target_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            wait_frame(n);
            chk("rev_up", {16'd0, width}, 1500 + 10 * k);
        end
        step(FRAME_CYC - 1);
        target_valid = 1'b1;
        target       = 16'd1400;
        step(1);
        target_valid = 1'b0;
        chk("rev_coinc_frame", {31'd0, frame}, 32'd1);
        chk("rev_coinc_width", {16'd0, width}, 32'd1540);
        chk("rev_coinc_ready", {31'd0, target_ready}, 32'd0);
        for (int k = 1; k <= 14; k++) begin
            wait_frame(n);
            chk("rev_period", n, FRAME_CYC);
            chk("rev_down", {16'd0, width}, 1540 - 10 * k);
            chk("rev_settled", {31'd0, settled}, (k == 14) ? 1 : 0);
        end

        // reset mid-slew with a pending target
        target_valid = 1'b1;
        target       = 16'd1600;
        step(1);
        target_valid = 1'b0;
        for (int k = 1; k <= 14; k++) wait_frame(n);
        chk("mid_width", {16'd0, width}, 32'd1540);
        target_valid = 1'b1;
        target       = 16'd1800;
        step(1);
        target_valid = 1'b0;
        chk("mid_pending", {31'd0, target_ready}, 32'd0);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mid_rst_width", {16'd0, width}, 32'd1500);
        chk("mid_rst_ready", {31'd0, target_ready}, 32'd1);
        chk("mid_rst_settled", {31'd0, settled}, 32'd1);
        chk("mid_rst_frame", {31'd0, frame}, 32'd0);
        wait_frame(n);
        chk("mid_rst_period", n, FRAME_CYC);
        chk("mid_rst_hold", {16'd0, width}, 32'd1500);
        chk("mid_rst_still", {31'd0, settled}, 32'd1);
        wait_frame(n);
        chk("mid_rst_discard", {16'd0, width}, 32'd1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
